// File: rtl/nms_frame_scheduler_if.sv
// Window handshake, NMS issue/return strobes, downstream credit return and result sidebands.
// master = upstream/NMS/buffer environment, slave = the scheduler.
interface nms_frame_scheduler_if #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    // Handshake: a window transfers in any cycle where s_valid && s_ready; that same
    // cycle raises nms_issue. s_valid may be held across cycles with s_ready low.
    logic          s_valid;
    logic          s_ready;
    logic          nms_issue;
    logic          nms_ret_valid;
    logic          credit_ret;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          res_border;
    logic          res_eol;
    logic          res_eof;

    modport master (
        output s_valid, nms_ret_valid, credit_ret,
        input  s_ready, nms_issue, col, row, res_border, res_eol, res_eof
    );

    modport slave (
        input  s_valid, nms_ret_valid, credit_ret,
        output s_ready, nms_issue, col, row, res_border, res_eol, res_eof
    );
endinterface

// File: rtl/nms_frame_scheduler.sv
// Frame sequencer for the NMS stage: credit-gated window issue, row/col tracking, aligned sidebands.
// Optional stall counter built only when NMS_SCHED_PERF_EN is defined.
module nms_frame_scheduler #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int NMS_LAT   = 3,
    parameter int OUT_DEPTH = 8,
    localparam int KW       = $clog2(OUT_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    nms_frame_scheduler_if.slave    bus,
    output logic                    err_sync,
    output logic                    err_credit,
    output logic [31:0]             stall_cnt,
    output logic [1:0]              state_dbg,
    output logic [KW-1:0]           credits
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t        state;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [KW-1:0] credit_q;
    logic [NMS_LAT:1] iss_sr;
    logic [NMS_LAT:1] brd_sr;
    logic [NMS_LAT:1] eol_sr;
    logic [NMS_LAT:1] eof_sr;

    logic ready;
    logic issue;
    logic at_eol;
    logic at_last;
    logic border;
    logic ret_full;
    logic frame_start;

    assign ready       = (state == RUN) && (credit_q != '0);
    assign issue       = bus.s_valid && ready;
    assign at_eol      = (col_q == CW'(IMG_W - 1));
    assign at_last     = at_eol && (row_q == RW'(IMG_H - 1));
    assign border      = (row_q == '0) || (row_q == RW'(IMG_H - 1)) || (col_q == '0) || at_eol;
    assign ret_full    = bus.credit_ret && (credit_q == KW'(OUT_DEPTH));
    assign frame_start = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            col_q <= '0;
            row_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        col_q <= '0;
                        row_q <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (at_last) begin
                            state <= DRAIN;
                            col_q <= '0;
                            row_q <= '0;
                        end else if (at_eol) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // In flight == any issue bit still travelling toward the result stage.
                    if (iss_sr == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A return at full credit is a downstream bookkeeping error; the count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= KW'(OUT_DEPTH);
        end else if (frame_start) begin
            credit_q <= KW'(OUT_DEPTH);
        end else if (issue && !bus.credit_ret) begin
            credit_q <= credit_q - 1'b1;
        end else if (!issue && bus.credit_ret && !ret_full) begin
            credit_q <= credit_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_sr     <= '0;
            brd_sr     <= '0;
            eol_sr     <= '0;
            eof_sr     <= '0;
            err_sync   <= 1'b0;
            err_credit <= 1'b0;
        end else begin
            iss_sr[1] <= issue;
            brd_sr[1] <= issue && border;
            eol_sr[1] <= issue && at_eol;
            eof_sr[1] <= issue && at_last;
            for (int i = 2; i <= NMS_LAT; i++) begin
                iss_sr[i] <= iss_sr[i-1];
                brd_sr[i] <= brd_sr[i-1];
                eol_sr[i] <= eol_sr[i-1];
                eof_sr[i] <= eof_sr[i-1];
            end
            err_sync   <= err_sync || (bus.nms_ret_valid != iss_sr[NMS_LAT]);
            err_credit <= err_credit || ret_full;
        end
    end

`ifdef NMS_SCHED_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            stall_q <= '0;
        end else if ((state == RUN) && bus.s_valid && !ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    assign busy           = (state == RUN) || (state == DRAIN);
    assign state_dbg      = state;
    assign credits        = credit_q;
    assign bus.s_ready    = ready;
    assign bus.nms_issue  = issue;
    assign bus.col        = col_q;
    assign bus.row        = row_q;
    assign bus.res_border = iss_sr[NMS_LAT] && brd_sr[NMS_LAT];
    assign bus.res_eol    = iss_sr[NMS_LAT] && eol_sr[NMS_LAT];
    assign bus.res_eof    = iss_sr[NMS_LAT] && eof_sr[NMS_LAT];
endmodule

// File: doc/nms_frame_scheduler.md
Name: nms_frame_scheduler

Overview:
Frame-level sequencer for the non-max-suppression stage of the edge-detector pipeline. Accepts the upstream 3x3 window stream (gradient magnitude plus direction) under valid/ready, and issues one window per cycle into the fixed-latency, non-stallable NMS datapath. Issue is gated by credits for the downstream output buffer. Tracks pixel row/column, flags border windows, and emits end-of-line/end-of-frame sidebands aligned with the NMS result valid.

Parameters:
IMG_W, 640, image width in pixels (>=2)
IMG_H, 480, image height in lines (>=2)
NMS_LAT, 3, NMS datapath latency in cycles, issue to result valid (>=1)
OUT_DEPTH, 8, downstream buffer slots = initial credit count (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle frame start request
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse at end of frame
s_valid  in  1  upstream window valid
s_ready  out  1  scheduler can accept a window
nms_issue  out  1  drives both NMS input-valid strobes; equals s_valid && s_ready
nms_ret_valid  in  1  NMS pixels-out valid
credit_ret  in  1  downstream freed one slot
col  out  clog2(IMG_W)  column of the window issued this cycle
row  out  clog2(IMG_H)  row of the window issued this cycle
res_border  out  1  result pixel lies on the image border (row 0/H-1, col 0/W-1); aligned with nms_ret_valid
res_eol  out  1  result is the last pixel of a line; aligned
res_eof  out  1  result is the last pixel of the frame; aligned
err_sync  out  1  sticky: nms_ret_valid differs from delayed issue
err_credit  out  1  sticky: credit_ret received with credits == OUT_DEPTH
stall_cnt  out  32  RUN cycles with s_valid && !s_ready (see optional feature)

Behaviour:
- Reset (rst high at a clk edge) has priority over everything, including mid-frame. It sets:
  - state=IDLE, credits=OUT_DEPTH, row=col=0;
  - every sideband shift stage cleared;
  - all outputs 0, including sticky errors and stall_cnt.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: s_ready=0. start moves to RUN and reloads credits=OUT_DEPTH, row=col=0.
  - RUN: s_ready = (credits != 0). nms_issue = s_valid && s_ready.
  - Issue of pixel (IMG_W-1, IMG_H-1) moves to DRAIN in the next cycle.
  - DRAIN: s_ready=0. Leave when the in-flight count is 0, i.e. no set issue bit remains in the NMS_LAT-deep shift register. Move to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored.
- Counters advance only on issue. col wraps IMG_W-1 -> 0 and increments row. row does not wrap within a frame.
- Credits:
  - issue without credit_ret: -1
  - credit_ret without issue: +1
  - both in the same cycle: unchanged
  - credit_ret at credits==OUT_DEPTH: credits hold (saturate) and err_credit is set.
  - credit_ret is honoured in every state.
- Sideband pipe: {issue, border, eol, eof} is computed from the current row/col at issue and shifted NMS_LAT stages. Stage NMS_LAT drives res_border/res_eol/res_eof, gated by the delayed issue bit; they are 0 when that bit is 0.
- Any cycle where nms_ret_valid != delayed issue bit sets err_sync. It is cleared only by rst.
- Throughput: 1 window/cycle while credits allow.
- Latency: s_valid to nms_issue is combinational (0 cycles); issue to res_* is NMS_LAT cycles.

Optional Feature:
- Macro NMS_SCHED_PERF_EN.
- Defined: stall_cnt increments in RUN each cycle s_valid=1 && s_ready=0. It saturates at 2^32-1 and clears on rst and on start.
- Undefined: stall_cnt is tied to 0 and no counter logic is built. The port remains present.

Test Plan:
All scenarios use IMG_W=4, IMG_H=3, NMS_LAT=3, OUT_DEPTH=2.
1. Basic frame: rst; start; s_valid=1 constantly; credit_ret pulsed 1 cycle after each res_* valid -> exactly 12 issues.
   - res_eol at results 4, 8 and 12; res_eof only at result 12.
   - res_border on all results except (1,1) and (2,1).
   - done pulses once; busy low afterwards.
2. Credit stall: no credit_ret -> s_ready drops after 2 issues and stays low. With PERF_EN, stall_cnt=5 after 5 further cycles. A single credit_ret -> exactly one further issue.
3. Simultaneous issue and credit_ret with credits=1 -> credits remain 1; issue proceeds the following cycle.
4. Protocol errors:
   - Drive nms_ret_valid=1 in a cycle with no delayed issue -> err_sync=1 and remains 1 until rst.
   - credit_ret at full credits -> err_credit=1, credits stay 2.
5. Reset mid-frame: rst after 5 issues -> next cycle busy=0, s_ready=0, res_* = 0. A new start re-issues from row=0, col=0.
6. Ignored start: start asserted in RUN and in DRAIN -> no counter reset; frame completes with 12 issues and one done.
